uart_host_driver: RTL and testbench

- Bus-side initiator for the memory-mapped UART: drives uart_sel, uart_wr_enable, uart_addr and wdata_mem, and samples uart_data.
- After reset it programs the baud divisor and control register, then runs a polling loop.
- The loop pushes bytes from a valid/ready byte source into the TX data register and pops received bytes out through a valid strobe, with error flags attached.
- Replaces a software polling driver in processor-less test systems and loaders.

---
 rtl/uart_host_pkg.sv | 26 ++
 rtl/uart_host_driver.sv | 161 ++++++++++++++++
 tb/tb_uart_host_driver.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_host_pkg.sv
// Register map, status bit positions and FSM states shared by the UART host driver.
package uart_host_pkg;

  localparam logic [3:0] UART_TXDATA = 4'h0;
  localparam logic [3:0] UART_RXDATA = 4'h4;
  localparam logic [3:0] UART_BAUD   = 4'h8;
  localparam logic [3:0] UART_CTRL   = 4'hC;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_RX_EMPTY   = 1;
  localparam int ST_PARITY_ERR = 2;
  localparam int ST_STOP_ERR   = 3;
  localparam int ST_BUSY       = 4;

  typedef enum logic [3:0] {
    INIT_BAUD,
    INIT_CTRL,
    POLL,
    POLL_WAIT,
    RX_RD,
    RX_WAIT,
    TX_WR,
    GAP
  } host_state_e;

endpackage

// File: rtl/uart_host_driver.sv
// Bus initiator for the memory-mapped UART: programs baud/ctrl after reset, then polls
// STATUS and moves bytes between a valid/ready TX source and an RX strobe output.
module uart_host_driver
  import uart_host_pkg::*;
#(
  parameter logic [15:0] BAUD_DIV  = 16'd434,
  parameter logic [3:0]  CTRL_INIT = 4'b0001,
  parameter int unsigned POLL_GAP  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  tx_byte,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic [1:0]  rx_err,
  output logic        init_done,
  output logic        uart_sel,
  output logic        uart_wr_enable,
  output logic [3:0]  uart_addr,
  output logic [31:0] wdata_mem,
  input  logic [31:0] uart_data
);

  localparam logic [3:0] GAP_LAST = 4'(POLL_GAP - 1);

  host_state_e state_q, state_d;
  logic       run_q, run_d;
  logic [3:0] gap_q, gap_d;
  logic [1:0] stat_err_q, stat_err_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic [1:0] rx_err_q, rx_err_d;
  logic       rx_valid_q, rx_valid_d;
  logic       init_done_q, init_done_d;

  logic unused_data_bits;
  assign unused_data_bits = ^uart_data[31:8];

  // run_q holds the bus quiet for the first cycle after reset so every output is 0 in reset.
  always_comb begin
    state_d     = state_q;
    run_d       = 1'b1;
    gap_d       = gap_q;
    stat_err_d  = stat_err_q;
    rx_byte_d   = rx_byte_q;
    rx_err_d    = rx_err_q;
    rx_valid_d  = 1'b0;
    init_done_d = init_done_q;
    if (run_q) begin
      case (state_q)
        INIT_BAUD: state_d = INIT_CTRL;
        INIT_CTRL: begin
          state_d     = POLL;
          init_done_d = 1'b1;
        end
        POLL:      state_d = POLL_WAIT;
        POLL_WAIT: begin
          stat_err_d = {uart_data[ST_STOP_ERR], uart_data[ST_PARITY_ERR]};
          gap_d      = 4'd0;
          if (!uart_data[ST_RX_EMPTY])
            state_d = RX_RD;
          else if (tx_valid && !uart_data[ST_TX_FULL])
            state_d = TX_WR;
          else if (POLL_GAP == 0)
            state_d = POLL;
          else
            state_d = GAP;
        end
        RX_RD:     state_d = RX_WAIT;
        RX_WAIT: begin
          rx_byte_d  = uart_data[7:0];
          rx_err_d   = stat_err_q;
          rx_valid_d = 1'b1;
          state_d    = POLL;
        end
        TX_WR:     state_d = POLL;
        GAP: begin
          if (gap_q == GAP_LAST) begin
            state_d = POLL;
            gap_d   = 4'd0;
          end else begin
            gap_d = gap_q + 4'd1;
          end
        end
        default:   state_d = INIT_BAUD;
      endcase
    end
  end

  // TX_WR re-checks tx_valid in the write cycle itself, so a withdrawn byte is never written.
  always_comb begin
    uart_sel       = 1'b0;
    uart_wr_enable = 1'b0;
    uart_addr      = 4'h0;
    wdata_mem      = 32'h0;
    tx_ready       = 1'b0;
    if (run_q) begin
      case (state_q)
        INIT_BAUD: begin
          uart_sel       = 1'b1;
          uart_wr_enable = 1'b1;
          uart_addr      = UART_BAUD;
          wdata_mem      = {16'h0, BAUD_DIV};
        end
        INIT_CTRL: begin
          uart_sel       = 1'b1;
          uart_wr_enable = 1'b1;
          uart_addr      = UART_CTRL;
          wdata_mem      = {28'h0, CTRL_INIT};
        end
        POLL: begin
          uart_sel  = 1'b1;
          uart_addr = UART_CTRL;
        end
        RX_RD: begin
          uart_sel  = 1'b1;
          uart_addr = UART_RXDATA;
        end
        TX_WR: begin
          if (tx_valid) begin
            uart_sel       = 1'b1;
            uart_wr_enable = 1'b1;
            uart_addr      = UART_TXDATA;
            wdata_mem      = {24'h0, tx_byte};
            tx_ready       = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= INIT_BAUD;
      run_q       <= 1'b0;
      gap_q       <= 4'd0;
      stat_err_q  <= 2'b00;
      rx_byte_q   <= 8'h00;
      rx_err_q    <= 2'b00;
      rx_valid_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      gap_q       <= gap_d;
      stat_err_q  <= stat_err_d;
      rx_byte_q   <= rx_byte_d;
      rx_err_q    <= rx_err_d;
      rx_valid_q  <= rx_valid_d;
      init_done_q <= init_done_d;
    end
  end

  assign rx_byte   = rx_byte_q;
  assign rx_err    = rx_err_q;
  assign rx_valid  = rx_valid_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_uart_host_driver.sv
// Directed bench for uart_host_driver with a small behavioural UART register model.
module tb_uart_host_driver;

  logic        clock;
  logic        reset;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [1:0]  rx_err;
  logic        init_done;
  logic        uart_sel;
  logic        uart_wr_enable;
  logic [3:0]  uart_addr;
  logic [31:0] wdata_mem;
  logic [31:0] uart_data;

  uart_host_driver dut (
    .clock          (clock),
    .reset          (reset),
    .tx_byte        (tx_byte),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_byte        (rx_byte),
    .rx_valid       (rx_valid),
    .rx_err         (rx_err),
    .init_done      (init_done),
    .uart_sel       (uart_sel),
    .uart_wr_enable (uart_wr_enable),
    .uart_addr      (uart_addr),
    .wdata_mem      (wdata_mem),
    .uart_data      (uart_data)
  );

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    int          cyc;
    logic        txr;
    logic        ini;
  } acc_t;

  acc_t       acc_q[$];
  logic [7:0] rx_fifo[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         full_polls = 0;
  logic       par_e = 0;
  logic       stop_e = 0;
  int         tx_wr_cnt = 0;
  int         txr_cnt = 0;
  int         rx_cnt = 0;
  logic [7:0] rx_last_byte = 0;
  logic [1:0] rx_last_err = 0;
  int         rx_last_cyc = 0;
  logic       rd_pend;
  logic [3:0] rd_addr;
  logic       full_now;

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Bus monitor plus UART register model: read data appears the cycle after the read.
  initial forever begin
    @(negedge clock);
    if (uart_sel) begin
      acc_q.push_back('{wr: uart_wr_enable, addr: uart_addr, data: wdata_mem,
                        cyc: cyc, txr: tx_ready, ini: init_done});
      if (uart_wr_enable && uart_addr == 4'h0) tx_wr_cnt++;
    end
    if (tx_ready) txr_cnt++;
    if (rx_valid) begin
      rx_cnt++;
      rx_last_byte = rx_byte;
      rx_last_err  = rx_err;
      rx_last_cyc  = cyc;
    end
    rd_pend = uart_sel && !uart_wr_enable;
    rd_addr = uart_addr;
    @(posedge clock);
    #1;
    uart_data = 32'hFFFF_FFFF;
    if (rd_pend && rd_addr == 4'hC) begin
      full_now  = (full_polls > 0);
      uart_data = {27'h0, 1'b0, stop_e, par_e, (rx_fifo.size() == 0), full_now};
      if (full_now) full_polls--;
    end else if (rd_pend && rd_addr == 4'h4 && rx_fifo.size() > 0) begin
      uart_data = {24'hA5A5A5, rx_fifo.pop_front()};
      par_e  = 0;
      stop_e = 0;
    end
  end

  task automatic next_acc(output acc_t a);
    int n = 0;
    logic got;
    while (acc_q.size() == 0 && n < 100) begin
      @(negedge clock);
      #1;
      n++;
    end
    got = (acc_q.size() > 0);
    if (!got) begin
      chk("acc_timeout", got, 1);
      a = '{wr: 0, addr: 0, data: 0, cyc: 0, txr: 0, ini: 0};
    end else begin
      a = acc_q.pop_front();
    end
  endtask

  task automatic sync_poll(output int c);
    acc_t a;
    logic found = 0;
    acc_q.delete();
    c = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      next_acc(a);
      if (!a.wr && a.addr == 4'hC) begin
        found = 1;
        c = a.cyc;
      end
    end
    if (!found) chk("sync_poll", found, 1);
  endtask

  task automatic check_init(input string tag);
    acc_t a;
    int c;
    next_acc(a);
    chk({tag, "_baud_wr"}, a.wr, 1);
    chk({tag, "_baud_addr"}, a.addr, 4'h8);
    chk({tag, "_baud_dat"}, a.data, 32'h0000_01B2);
    chk({tag, "_baud_done"}, a.ini, 0);
    c = a.cyc;
    next_acc(a);
    chk({tag, "_ctrl_wr"}, a.wr, 1);
    chk({tag, "_ctrl_addr"}, a.addr, 4'hC);
    chk({tag, "_ctrl_dat"}, a.data, 32'h0000_0001);
    chk({tag, "_ctrl_cyc"}, a.cyc - c, 1);
    chk({tag, "_ctrl_done"}, a.ini, 0);
    next_acc(a);
    chk({tag, "_poll_rd"}, a.wr, 0);
    chk({tag, "_poll_addr"}, a.addr, 4'hC);
    chk({tag, "_poll_cyc"}, a.cyc - c, 2);
    chk({tag, "_done"}, a.ini, 1);
  endtask

  task automatic drop_tx();
    @(posedge clock);
    #2;
    tx_valid = 0;
  endtask

  initial begin
    acc_t a;
    int c, last, reads, n0, t0, r0;
    logic found;
    reset = 0;
    tx_valid = 0;
    tx_byte = 0;
    uart_data = 32'hFFFF_FFFF;
    repeat (3) @(negedge clock);
    chk("rst_outs", {tx_ready, rx_byte, rx_valid, rx_err, init_done, uart_sel,
                     uart_wr_enable, uart_addr, wdata_mem}, 64'd0);
    @(posedge clock);
    #2;
    reset = 1;
    check_init("init");
    sync_poll(c);
    next_acc(a);
    chk("idle_poll_addr", a.addr, 4'hC);
    chk("idle_poll_gap", a.cyc - c, 6);

    // Single TX byte with empty FIFOs
    sync_poll(c);
    tx_byte = 8'h5A;
    tx_valid = 1;
    n0 = tx_wr_cnt;
    t0 = txr_cnt;
    next_acc(a);
    chk("tx_wr", a.wr, 1);
    chk("tx_addr", a.addr, 4'h0);
    chk("tx_dat", a.data, 32'h0000_005A);
    chk("tx_rdy", a.txr, 1);
    chk("tx_cyc", a.cyc - c, 2);
    drop_tx();
    repeat (20) @(negedge clock);
    chk("tx_one_wr", tx_wr_cnt - n0, 1);
    chk("tx_one_rdy", txr_cnt - t0, 1);

    // TX FIFO full for three polls
    sync_poll(c);
    full_polls = 3;
    tx_valid = 1;
    reads = 0;
    last = c;
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      next_acc(a);
      if (a.wr) found = 1;
      else begin
        reads++;
        last = a.cyc;
      end
    end
    chk("full_reads", reads, 3);
    chk("full_addr", a.addr, 4'h0);
    chk("full_dat", a.data, 32'h0000_005A);
    chk("full_cyc", a.cyc - last, 2);
    drop_tx();

    // RX byte with parity error
    sync_poll(c);
    rx_fifo.push_back(8'hC3);
    par_e = 1;
    r0 = rx_cnt;
    next_acc(a);
    chk("rx_rd", a.wr, 0);
    chk("rx_addr", a.addr, 4'h4);
    chk("rx_rd_cyc", a.cyc - c, 2);
    repeat (4) @(negedge clock);
    chk("rx_cnt", rx_cnt - r0, 1);
    chk("rx_byte", rx_last_byte, 8'hC3);
    chk("rx_err", rx_last_err, 2'b01);
    chk("rx_cyc", rx_last_cyc - c, 4);
    chk("rx_hold", rx_byte, 8'hC3);
    chk("rx_strobe_low", rx_valid, 0);

    // RX and TX both pending: RX first
    sync_poll(c);
    rx_fifo.push_back(8'h3C);
    tx_byte = 8'hA5;
    tx_valid = 1;
    r0 = rx_cnt;
    next_acc(a);
    chk("both_rx_addr", a.addr, 4'h4);
    chk("both_rx_cyc", a.cyc - c, 2);
    next_acc(a);
    chk("both_poll_addr", {a.wr, a.addr}, {1'b0, 4'hC});
    chk("both_poll_cyc", a.cyc - c, 4);
    next_acc(a);
    chk("both_tx", {a.wr, a.addr, a.txr}, {1'b1, 4'h0, 1'b1});
    chk("both_tx_dat", a.data, 32'h0000_00A5);
    chk("both_tx_cyc", a.cyc - c, 6);
    drop_tx();
    chk("both_rx_byte", rx_last_byte, 8'h3C);
    chk("both_rx_err", rx_last_err, 2'b00);
    chk("both_rx_cnt", rx_cnt - r0, 1);

    // Reset during RX_WAIT
    sync_poll(c);
    rx_fifo.push_back(8'h77);
    r0 = rx_cnt;
    next_acc(a);
    chk("rst_rx_addr", a.addr, 4'h4);
    @(posedge clock);
    #2;
    reset = 0;
    #1;
    chk("rst_mid_outs", {tx_ready, rx_byte, rx_valid, rx_err, init_done, uart_sel,
                         uart_wr_enable, uart_addr, wdata_mem}, 64'd0);
    repeat (5) @(negedge clock);
    chk("rst_no_rx", rx_cnt - r0, 0);
    acc_q.delete();
    @(posedge clock);
    #2;
    reset = 1;
    check_init("reinit");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

endmodule
